decoupled_v_rr_merge: RTL and testbench

- Merges NumIn valid-only (no-ready) producer streams onto one valid-only consumer stream.
- Sits in the Cohort tile, where several engines share one response/telemetry channel.
- Valid-only links cannot backpressure, so each input has a small FIFO. A round-robin scheduler drains the FIFOs at one beat per cycle.
- Overflow drops are counted and flagged, never silent.

---
 rtl/decoupled_v_merge_pkg.sv | 36 +++
 rtl/decoupled_v_fifo.sv | 50 +++++
 rtl/decoupled_v_rr_merge.sv | 99 +++++++++
 tb/tb_decoupled_v_rr_merge.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoupled_v_merge_pkg.sv
// Shared types and the round-robin pick helper for the valid-only merge.
package decoupled_v_merge_pkg;

  localparam int unsigned MaxNumIn        = 8;
  localparam int unsigned IdxW            = $clog2(MaxNumIn);
  localparam int unsigned DefNumIn        = 4;
  localparam int unsigned DefFifoDepth    = 4;
  localparam int unsigned DefDropCntWidth = 8;

  typedef logic [$clog2(DefNumIn)-1:0] src_idx_t;

  typedef struct packed {
    logic            found;
    logic [IdxW-1:0] idx;
  } rr_pick_t;

  // First requester at or after ptr, wrapping modulo num (num <= MaxNumIn).
  function automatic rr_pick_t rr_pick(input logic [MaxNumIn-1:0] req,
                                       input int unsigned         ptr,
                                       input int unsigned         num);
    rr_pick_t        res;
    int unsigned     cand;
    logic [IdxW-1:0] cidx;
    res = '0;
    for (int unsigned k = 0; k < MaxNumIn; k++) begin
      cand = (ptr + k) % num;
      cidx = IdxW'(cand);
      if ((k < num) && !res.found && req[cidx]) begin
        res.found = 1'b1;
        res.idx   = cidx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/decoupled_v_fifo.sv
// Small per-producer FIFO; a push to a full FIFO is only accepted when it pops the same cycle.
module decoupled_v_fifo #(
  parameter int DataWidth = 64,
  parameter int Depth     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DataWidth-1:0] push_data,
  input  logic                 pop,
  output logic [DataWidth-1:0] head_data,
  output logic                 empty,
  output logic                 full
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic [CntW-1:0]      count;
  logic                 wr_en;
  logic                 rd_en;

  assign empty     = (count == '0);
  assign full      = (count == CntW'(Depth));
  assign rd_en     = pop & ~empty;
  assign wr_en     = push & (~full | rd_en);
  assign head_data = mem[rd_ptr];

  // Pointer and occupancy tracking; reset discards everything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CntW'(wr_en) - CntW'(rd_en);
    end
  end

  // Payload storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/decoupled_v_rr_merge.sv
// Merges NumIn valid-only streams through per-input FIFOs and a round-robin drain.
module decoupled_v_rr_merge
  import decoupled_v_merge_pkg::*;
#(
  parameter int NumIn        = DefNumIn,
  parameter int DataWidth    = 64,
  parameter int FifoDepth    = DefFifoDepth,
  parameter int DropCntWidth = DefDropCntWidth
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NumIn-1:0]              in_valid,
  input  logic [NumIn*DataWidth-1:0]    in_data,
  output logic                          out_valid,
  output logic [DataWidth-1:0]          out_data,
  output logic [$clog2(NumIn)-1:0]      out_src,
  output logic [NumIn-1:0]              overflow,
  output logic [NumIn*DropCntWidth-1:0] drop_cnt,
  input  logic                          clear_err
);

  localparam int SrcW = $clog2(NumIn);

  logic [NumIn-1:0]        fifo_empty;
  logic [NumIn-1:0]        fifo_full;
  logic [NumIn-1:0]        fifo_pop;
  logic [NumIn-1:0]        drop;
  logic [DataWidth-1:0]    head_data [NumIn];
  logic [DropCntWidth-1:0] cnt_q [NumIn];
  logic [MaxNumIn-1:0]     req;
  rr_pick_t                pick;
  logic [SrcW-1:0]         grant_idx;
  logic [SrcW-1:0]         rr_ptr;

  for (genvar gi = 0; gi < NumIn; gi++) begin : g_in
    decoupled_v_fifo #(
      .DataWidth (DataWidth),
      .Depth     (FifoDepth)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in_valid[gi]),
      .push_data (in_data[gi*DataWidth +: DataWidth]),
      .pop       (fifo_pop[gi]),
      .head_data (head_data[gi]),
      .empty     (fifo_empty[gi]),
      .full      (fifo_full[gi])
    );
    assign drop[gi] = in_valid[gi] & fifo_full[gi] & ~fifo_pop[gi];
    assign drop_cnt[gi*DropCntWidth +: DropCntWidth] = cnt_q[gi];
  end

  // Grant the first non-empty FIFO at or after rr_ptr and pop it this cycle.
  always_comb begin
    req              = '0;
    req[NumIn-1:0]   = ~fifo_empty;
    pick             = rr_pick(req, 32'(rr_ptr), NumIn);
    grant_idx        = SrcW'(pick.idx);
    fifo_pop         = '0;
    if (pick.found) fifo_pop[grant_idx] = 1'b1;
  end

  // Output register and pointer advance; data/src hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (pick.found) begin
      out_valid <= 1'b1;
      out_data  <= head_data[grant_idx];
      out_src   <= grant_idx;
      rr_ptr    <= (grant_idx == SrcW'(NumIn - 1)) ? '0 : grant_idx + 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

  // Sticky drop flags and saturating counters; a same-cycle drop beats clear_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= '0;
      for (int i = 0; i < NumIn; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumIn; i++) begin
        if (drop[i]) begin
          overflow[i] <= 1'b1;
          if (clear_err) cnt_q[i] <= DropCntWidth'(1);
          else if (cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (clear_err) begin
          overflow[i] <= 1'b0;
          cnt_q[i]    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_decoupled_v_rr_merge.sv
// Self-checking bench: queue-based reference model, vector table and corner sequences.
module tb_decoupled_v_rr_merge;
  import decoupled_v_merge_pkg::*;

  localparam int NumIn        = 4;
  localparam int DataWidth    = 64;
  localparam int FifoDepth    = 4;
  localparam int DropCntWidth = 8;
  localparam int CntMax       = (1 << DropCntWidth) - 1;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic [NumIn-1:0]              in_valid;
  logic [NumIn*DataWidth-1:0]    in_data;
  logic                          out_valid;
  logic [DataWidth-1:0]          out_data;
  logic [$clog2(NumIn)-1:0]      out_src;
  logic [NumIn-1:0]              overflow;
  logic [NumIn*DropCntWidth-1:0] drop_cnt;
  logic                          clear_err;

  decoupled_v_rr_merge #(
    .NumIn        (NumIn),
    .DataWidth    (DataWidth),
    .FifoDepth    (FifoDepth),
    .DropCntWidth (DropCntWidth)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .clear_err (clear_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fail_lines = 0;

  // Reference model state: one queue per input plus expected output registers.
  logic [DataWidth-1:0] mq [NumIn][$];
  int                   m_ptr;
  logic                 m_valid;
  logic [DataWidth-1:0] m_data;
  int                   m_src;
  logic [NumIn-1:0]     m_ovf;
  int                   m_cnt [NumIn];
  int                   m_raw [NumIn];

  typedef struct {
    logic [NumIn-1:0]     vld;
    logic [DataWidth-1:0] d2;
    logic                 exp_valid;
    logic [DataWidth-1:0] exp_data;
    src_idx_t             exp_src;
  } vec_t;

  vec_t tbl [4];

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      if (fail_lines < 40)
        $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      fail_lines++;
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NumIn; i++) begin
      mq[i].delete();
      m_cnt[i] = 0;
      m_raw[i] = 0;
    end
    m_ptr   = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    m_ovf   = '0;
  endtask

  function automatic int modelGrant();
    for (int k = 0; k < NumIn; k++)
      if (mq[(m_ptr + k) % NumIn].size() != 0) return (m_ptr + k) % NumIn;
    return -1;
  endfunction

  task automatic modelStep(input logic [NumIn-1:0] vld, input logic [NumIn*DataWidth-1:0] dat,
                           input logic clr);
    int g;
    bit was_full [NumIn];
    bit dropped;
    for (int i = 0; i < NumIn; i++) was_full[i] = (mq[i].size() == FifoDepth);
    g = modelGrant();
    if (g >= 0) begin
      m_data  = mq[g].pop_front();
      m_src   = g;
      m_valid = 1'b1;
      m_ptr   = (g + 1) % NumIn;
    end else begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < NumIn; i++) begin
      dropped = vld[i] && was_full[i] && (g != i);
      if (dropped) begin
        m_raw[i]++;
        m_ovf[i] = 1'b1;
        m_cnt[i] = clr ? 1 : ((m_cnt[i] < CntMax) ? m_cnt[i] + 1 : CntMax);
      end else begin
        if (clr) begin
          m_ovf[i] = 1'b0;
          m_cnt[i] = 0;
        end
        if (vld[i]) mq[i].push_back(dat[i*DataWidth +: DataWidth]);
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    checkVal({tag, ".out_data"}, out_data, m_data);
    checkVal({tag, ".out_src"}, 64'(out_src), 64'(m_src));
    checkVal({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
    for (int i = 0; i < NumIn; i++)
      checkVal($sformatf("%s.drop_cnt%0d", tag, i),
               64'(drop_cnt[i*DropCntWidth +: DropCntWidth]), 64'(m_cnt[i]));
  endtask

  task automatic applyStimulus(input logic [NumIn-1:0] vld, input logic [NumIn*DataWidth-1:0] dat,
                               input logic clr, input string tag);
    in_valid  = vld;
    in_data   = dat;
    clear_err = clr;
    @(posedge clk);
    modelStep(vld, dat, clr);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    clear_err = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset");
    rst_n = 1'b1;
  endtask

  function automatic int dutCnt(input int i);
    return int'(drop_cnt[i*DropCntWidth +: DropCntWidth]);
  endfunction

  function automatic bit modelEmpty();
    for (int i = 0; i < NumIn; i++) if (mq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // All inputs valid for ncyc cycles, then drain; checks gaps, drop accounting and ordering.
  task automatic burstTest(input int ncyc, input string tag, input bit expect_rr,
                           input int exp_drops, input logic [NumIn-1:0] exp_ovf);
    logic [NumIn*DataWidth-1:0] dat;
    logic                       vlog [$];
    int                         slog [$];
    logic [DataWidth-1:0]       dlog [$];
    int                         last_seq [NumIn];
    int                         delivered, gaps, first, last, sumdrop, budget;
    bit                         rr_ok, seq_ok;
    logic [NumIn-1:0]           ovf_from_cnt;
    doReset();
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < NumIn; i++) dat[i*DataWidth +: DataWidth] = {32'(i), 32'(c)};
      applyStimulus('1, dat, 1'b0, tag);
      vlog.push_back(out_valid);
      slog.push_back(int'(out_src));
      dlog.push_back(out_data);
    end
    budget = 0;
    while ((!modelEmpty() || m_valid) && budget < 60) begin
      applyStimulus('0, '0, 1'b0, tag);
      vlog.push_back(out_valid);
      slog.push_back(int'(out_src));
      dlog.push_back(out_data);
      budget++;
    end
    checkVal({tag, ".drained"}, 64'(budget < 60), 64'd1);
    delivered = 0; gaps = 0; first = -1; last = -1;
    for (int k = 0; k < vlog.size(); k++)
      if (vlog[k]) begin
        if (first < 0) first = k;
        last = k;
        delivered++;
      end
    for (int k = first; k >= 0 && k <= last; k++) if (!vlog[k]) gaps++;
    checkVal({tag, ".gaps"}, 64'(gaps), 64'd0);
    sumdrop = 0;
    for (int i = 0; i < NumIn; i++) begin
      sumdrop += dutCnt(i);
      ovf_from_cnt[i] = (dutCnt(i) != 0);
      last_seq[i] = -1;
    end
    checkVal({tag, ".drop_plus_out"}, 64'(sumdrop + delivered), 64'(ncyc * NumIn));
    checkVal({tag, ".drop_sum"}, 64'(sumdrop), 64'(exp_drops));
    checkVal({tag, ".ovf_vs_cnt"}, 64'(overflow), 64'(ovf_from_cnt));
    checkVal({tag, ".ovf_bits"}, 64'(overflow), 64'(exp_ovf));
    rr_ok = 1'b1; seq_ok = 1'b1;
    delivered = 0;
    for (int k = 0; k < vlog.size(); k++)
      if (vlog[k]) begin
        if (slog[k] != delivered % NumIn) rr_ok = 1'b0;
        if (int'(dlog[k][63:32]) != slog[k]) seq_ok = 1'b0;
        if (int'(dlog[k][31:0]) <= last_seq[slog[k]]) seq_ok = 1'b0;
        last_seq[slog[k]] = int'(dlog[k][31:0]);
        delivered++;
      end
    if (expect_rr) checkVal({tag, ".rr_order"}, 64'(rr_ok), 64'd1);
    checkVal({tag, ".seq_order"}, 64'(seq_ok), 64'd1);
  endtask

  initial begin
    logic [NumIn*DataWidth-1:0] dat;
    int                         g, steps, steady;
    bit                         hit;

    rst_n = 1'b1; in_valid = '0; in_data = '0; clear_err = 1'b0;
    #2;

    // Single beat on input 2: table of expected outputs per cycle.
    tbl[0] = '{vld: 4'b0100, d2: 64'hA5, exp_valid: 1'b0, exp_data: 64'h0,  exp_src: 2'd0};
    tbl[1] = '{vld: 4'b0000, d2: 64'h0,  exp_valid: 1'b1, exp_data: 64'hA5, exp_src: 2'd2};
    tbl[2] = '{vld: 4'b0000, d2: 64'h0,  exp_valid: 1'b0, exp_data: 64'hA5, exp_src: 2'd2};
    tbl[3] = '{vld: 4'b0000, d2: 64'h0,  exp_valid: 1'b0, exp_data: 64'hA5, exp_src: 2'd2};
    doReset();
    for (int v = 0; v < 4; v++) begin
      dat = '0;
      dat[2*DataWidth +: DataWidth] = tbl[v].d2;
      applyStimulus(tbl[v].vld, dat, 1'b0, $sformatf("single%0d", v));
      checkVal($sformatf("tbl%0d.valid", v), 64'(out_valid), 64'(tbl[v].exp_valid));
      checkVal($sformatf("tbl%0d.data", v), out_data, tbl[v].exp_data);
      checkVal($sformatf("tbl%0d.src", v), 64'(out_src), 64'(tbl[v].exp_src));
    end

    // Fairness and overflow bursts.
    burstTest(8, "fair", 1'b1, 9, 4'b1111);
    burstTest(6, "ovf", 1'b0, 3, 4'b1110);

    // Fill FIFO 0 through contention, then feed it alone while full.
    doReset();
    for (int c = 0; c < 3; c++) begin
      dat = '0;
      dat[0 +: DataWidth] = 64'(c);
      dat[DataWidth +: DataWidth] = 64'(100 + c);
      applyStimulus(4'b0011, dat, 1'b0, "fill");
    end
    steady = 0;
    for (int c = 0; c < 16; c++) begin
      dat = '0;
      dat[0 +: DataWidth] = 64'(3 + c);
      applyStimulus(4'b0001, dat, 1'b0, "fullpop");
      if (c >= 6 && out_valid && out_src == '0) steady++;
    end
    checkVal("fullpop.steady", 64'(steady), 64'd10);
    checkVal("fullpop.overflow0", 64'(overflow[0]), 64'd0);
    checkVal("fullpop.drop0", 64'(dutCnt(0)), 64'd0);

    // clear_err in the same cycle as a drop on input 1.
    doReset();
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      dat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      g = modelGrant();
      if (mq[1].size() == FifoDepth && g != 1 && m_raw[1] >= 2) begin
        applyStimulus(4'b0011, dat, 1'b1, "collide");
        hit = 1'b1;
      end else begin
        applyStimulus(4'b0011, dat, 1'b0, "prefill");
      end
    end
    checkVal("collide.reached", 64'(hit), 64'd1);
    checkVal("collide.overflow", 64'(overflow), 64'b0010);
    checkVal("collide.cnt1", 64'(dutCnt(1)), 64'd1);
    checkVal("collide.cnt0", 64'(dutCnt(0)), 64'd0);
    checkVal("collide.cnt23", 64'(dutCnt(2) + dutCnt(3)), 64'd0);

    // Asynchronous reset with three beats still buffered.
    doReset();
    for (int i = 0; i < NumIn; i++) dat[i*DataWidth +: DataWidth] = 64'(16'hBEE0 + i);
    applyStimulus('1, dat, 1'b0, "prereset");
    applyStimulus('0, '0, 1'b0, "prereset");
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset");
    checkVal("async_reset.valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) applyStimulus('0, '0, 1'b0, "no_stale");
    dat = '0;
    dat[0 +: DataWidth] = 64'h111;
    dat[3*DataWidth +: DataWidth] = 64'h333;
    applyStimulus(4'b1001, dat, 1'b0, "restart");
    applyStimulus('0, '0, 1'b0, "restart");
    checkVal("restart.src", 64'(out_src), 64'd0);
    checkVal("restart.data", out_data, 64'h111);
    applyStimulus('0, '0, 1'b0, "restart");
    checkVal("restart.src2", 64'(out_src), 64'd3);

    // Saturate the drop counter on input 3.
    doReset();
    steps = 0;
    while (m_raw[3] < 300 && steps < 2000) begin
      dat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      applyStimulus(4'b1100, dat, 1'b0, "sat");
      steps++;
    end
    checkVal("sat.reached", 64'(m_raw[3] >= 300), 64'd1);
    checkVal("sat.cnt3", 64'(dutCnt(3)), 64'(CntMax));
    checkVal("sat.ovf3", 64'(overflow[3]), 64'd1);

    // Randomized traffic against the model.
    doReset();
    for (int c = 0; c < 400; c++) begin
      dat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      applyStimulus(NumIn'($urandom_range(0, 15)), dat, ($urandom_range(0, 19) == 0), "rand");
    end
    in_valid = '0;

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Hard stop in case a wait never returns.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
